// File: rtl/hilo_unit.sv
// hilo_unit: iterative multiply/divide unit that owns HI and LO.
// One shift-add or shift-subtract step per clock; MTHI/MTLO are single cycle.
module hilo_unit #(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         operacao,
    input  logic [LARGURA-1:0] opA,
    input  logic [LARGURA-1:0] opB,
    input  logic               selHiLo,
    output logic [LARGURA-1:0] HiLoData,
    output logic               ocupado,
    output logic               pronto,
    output logic               erroDiv
);

    localparam int W  = LARGURA;
    localparam int CW = $clog2(LARGURA) + 1;
    localparam logic [CW-1:0] LAST = CW'(LARGURA - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIM
    } estadoT;

    estadoT estado;
    estadoT proxEstado;

    logic [W-1:0]  hiReg;
    logic [W-1:0]  loReg;
    logic [W-1:0]  accHi;
    logic [W-1:0]  accLo;
    logic [W-1:0]  magB;
    logic [CW-1:0] count;
    logic          opDiv;
    logic          negHi;
    logic          negLo;
    logic          zeroPend;
    logic          erroReg;
    logic          prontoReg;
    logic          prontoNext;

    logic isMul;
    logic isDiv;
    logic isSigned;
    logic isMthi;
    logic isMtlo;

    // Decode the requested operation class.
    always_comb begin
        isMul    = 1'b0;
        isDiv    = 1'b0;
        isSigned = 1'b0;
        isMthi   = 1'b0;
        isMtlo   = 1'b0;
        unique case (1'b1)
            (operacao == OP_MULT): begin
                isMul    = 1'b1;
                isSigned = 1'b1;
            end
            (operacao == OP_MULTU): isMul = 1'b1;
            (operacao == OP_DIV): begin
                isDiv    = 1'b1;
                isSigned = 1'b1;
            end
            (operacao == OP_DIVU): isDiv = 1'b1;
            (operacao == OP_MTHI): isMthi = 1'b1;
            (operacao == OP_MTLO): isMtlo = 1'b1;
            default: ;
        endcase
    end

    logic         idleStart;
    logic         accOp;
    logic         divZero;
    logic         negA;
    logic         negB;
    logic [W-1:0] absA;
    logic [W-1:0] absB;

    assign idleStart = (estado == IDLE) && start;
    assign accOp     = idleStart && (isMul || isDiv);
    assign divZero   = isDiv && (opB == '0);
    assign negA      = isSigned && opA[W-1];
    assign negB      = isSigned && opB[W-1];
    assign absA      = negA ? -opA : opA;
    assign absB      = negB ? -opB : opB;

    // accHi/accLo hold the running product (hi:lo) or remainder:quotient.
    logic [W:0]   mulSum;
    logic [W:0]   divShift;
    logic [W:0]   divDiff;
    logic         divFits;
    logic [W-1:0] stepHi;
    logic [W-1:0] stepLo;

    // One iteration step: shift-add for multiply, restoring divide otherwise.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, magB} : '0);
        divShift = {accHi, accLo[W-1]};
        divDiff  = divShift - {1'b0, magB};
        divFits  = ~divDiff[W];
        if (opDiv) begin
            stepHi = divFits ? divDiff[W-1:0] : divShift[W-1:0];
            stepLo = {accLo[W-2:0], divFits};
        end else begin
            stepHi = mulSum[W:1];
            stepLo = {mulSum[0], accLo[W-1:1]};
        end
    end

    logic [2*W-1:0] prodFix;
    logic [W-1:0]   quoFix;
    logic [W-1:0]   remFix;
    logic [W-1:0]   finHi;
    logic [W-1:0]   finLo;

    // Sign correction applied when the result is committed.
    always_comb begin
        prodFix = negLo ? -{accHi, accLo} : {accHi, accLo};
        quoFix  = negLo ? -accLo : accLo;
        remFix  = negHi ? -accHi : accHi;
        finHi   = opDiv ? remFix : prodFix[2*W-1:W];
        finLo   = opDiv ? quoFix : prodFix[W-1:0];
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= IDLE;
        end else begin
            estado <= proxEstado;
        end
    end

    // Next state; the done pulse is raised on leaving FIM.
    always_comb begin
        proxEstado = estado;
        prontoNext = 1'b0;
        unique case (estado)
            IDLE: begin
                if (accOp) begin
                    proxEstado = divZero ? FIM : CALC;
                end
            end
            CALC: begin
                if (count == LAST) begin
                    proxEstado = FIM;
                end
            end
            FIM: begin
                proxEstado = IDLE;
                prontoNext = 1'b1;
            end
            default: proxEstado = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and HI/LO commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hiReg     <= '0;
            loReg     <= '0;
            accHi     <= '0;
            accLo     <= '0;
            magB      <= '0;
            count     <= '0;
            opDiv     <= 1'b0;
            negHi     <= 1'b0;
            negLo     <= 1'b0;
            zeroPend  <= 1'b0;
            erroReg   <= 1'b0;
            prontoReg <= 1'b0;
        end else begin
            prontoReg <= prontoNext;
            unique case (estado)
                IDLE: begin
                    if (accOp) begin
                        accHi    <= '0;
                        accLo    <= absA;
                        magB     <= absB;
                        count    <= '0;
                        opDiv    <= isDiv;
                        zeroPend <= divZero;
                        negLo    <= negA ^ negB;
                        negHi    <= isDiv ? negA : (negA ^ negB);
                        if (!divZero) begin
                            erroReg <= 1'b0;
                        end
                    end else if (idleStart && isMthi) begin
                        hiReg <= opA;
                    end else if (idleStart && isMtlo) begin
                        loReg <= opA;
                    end
                end
                CALC: begin
                    accHi <= stepHi;
                    accLo <= stepLo;
                    count <= count + 1'b1;
                end
                FIM: begin
                    if (zeroPend) begin
                        erroReg <= 1'b1;
                    end else begin
                        hiReg <= finHi;
                        loReg <= finLo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocupado  = (estado == CALC) || (estado == FIM);
    assign pronto   = prontoReg;
    assign erroDiv  = erroReg;
    assign HiLoData = selHiLo ? hiReg : loReg;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: randomized scoreboard bench for hilo_unit.
// Driver predicts results arithmetically; a monitor checks on each pronto.
module tb_hilo_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start;
    logic [2:0]  operacao;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        selHiLo;
    logic [31:0] HiLoData;
    logic        ocupado;
    logic        pronto;
    logic        erroDiv;

    hilo_unit #(.LARGURA(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .operacao (operacao),
        .opA      (opA),
        .opB      (opB),
        .selHiLo  (selHiLo),
        .HiLoData (HiLoData),
        .ocupado  (ocupado),
        .pronto   (pronto),
        .erroDiv  (erroDiv)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } expT;

    expT sb[$];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic        mErr = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Reference: plain 64-bit arithmetic; returns latency (0 = no result).
    task automatic predict(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int lat);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [63:0] sp;
        logic [63:0]        up;
        longint             q;
        longint             r;
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        lat = 0;
        case (op)
            3'd1: begin
                sp = sa * sbv;
                mHi = sp[63:32]; mLo = sp[31:0]; mErr = 1'b0; lat = 33;
            end
            3'd2: begin
                up = {32'b0, a} * {32'b0, b};
                mHi = up[63:32]; mLo = up[31:0]; mErr = 1'b0; lat = 33;
            end
            3'd3, 3'd4: begin
                if (b == 0) begin
                    mErr = 1'b1; lat = 1;
                end else begin
                    if (op == 3'd3) begin
                        q = sa / sbv;
                        r = sa % sbv;
                    end else begin
                        q = longint'({32'b0, a}) / longint'({32'b0, b});
                        r = longint'({32'b0, a}) % longint'({32'b0, b});
                    end
                    mLo = q[31:0]; mHi = r[31:0]; mErr = 1'b0; lat = 33;
                end
            end
            3'd5: mHi = a;
            3'd6: mLo = a;
            default: ;
        endcase
    endtask

    task automatic doOp(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int pulseAt,
                        input logic [2:0] pOp, input logic [31:0] pA,
                        input logic [31:0] pB);
        int lat;
        int got;
        expT x;
        @(negedge clock);
        start = 1'b1; operacao = op; opA = a; opB = b;
        predict(op, a, b, lat);
        if (lat != 0) begin
            x.hi = mHi; x.lo = mLo; x.err = mErr;
            sb.push_back(x);
        end
        @(posedge clock);
        #1;
        start = 1'b0; opA = $urandom; opB = $urandom;
        operacao = 3'($urandom);
        if (lat == 0) begin
            chk("ocupado idle op", 32'(ocupado), 0);
            chk("erroDiv after idle op", 32'(erroDiv), 32'(mErr));
            repeat (2) begin
                @(posedge clock);
                #1;
                chk("no pronto idle op", 32'(pronto), 0);
            end
        end else begin
            chk("ocupado after E0", 32'(ocupado), 1);
            got = 0;
            for (int e = 1; e <= 40 && got == 0; e++) begin
                if (e == pulseAt) begin
                    start = 1'b1; operacao = pOp; opA = pA; opB = pB;
                end
                @(posedge clock);
                #1;
                start = 1'b0;
                if (pronto) got = e;
                else chk("ocupado in flight", 32'(ocupado), 1);
            end
            chk("latency", 32'(got), 32'(lat));
            chk("ocupado at pronto", 32'(ocupado), 0);
            @(posedge clock);
            #1;
            chk("pronto one cycle", 32'(pronto), 0);
        end
    endtask

    // Monitor: on every pronto pop the expectation and read both HI and LO.
    initial begin
        expT x;
        selHiLo = 1'b0;
        @(negedge reset);
        @(negedge clock);
        selHiLo = 1'b1;
        #1 chk("reset HI", HiLoData, 0);
        selHiLo = 1'b0;
        #1 chk("reset LO", HiLoData, 0);
        forever begin
            @(negedge clock);
            if (pronto) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious pronto: got 1 expected 0");
                end else begin
                    x = sb.pop_front();
                    selHiLo = 1'b1;
                    #1 chk("HI", HiLoData, x.hi);
                    selHiLo = 1'b0;
                    #1 chk("LO", HiLoData, x.lo);
                    chk("erroDiv", 32'(erroDiv), 32'(x.err));
                end
            end
        end
    end

    // Driver: directed cases, random traffic, then async reset mid-op.
    initial begin
        logic [2:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        start = 1'b0; operacao = '0; opA = '0; opB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset ocupado", 32'(ocupado), 0);
        chk("reset pronto", 32'(pronto), 0);
        chk("reset erroDiv", 32'(erroDiv), 0);

        doOp(3'd1, 32'hFFFF_FFFD, 32'd7, 0, 3'd0, 0, 0);
        doOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'd0, 0, 0);
        doOp(3'd4, 32'd100, 32'd7, 0, 3'd0, 0, 0);
        doOp(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 0, 0);
        doOp(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 0, 0);
        doOp(3'd5, 32'h0000_1234, 32'd0, 0, 3'd0, 0, 0);
        doOp(3'd3, 32'd5, 32'd0, 0, 3'd0, 0, 0);
        doOp(3'd6, 32'hCAFE_F00D, 32'd0, 0, 3'd0, 0, 0);
        doOp(3'd4, 32'd9, 32'd0, 0, 3'd0, 0, 0);
        doOp(3'd1, 32'd2, 32'd3, 0, 3'd0, 0, 0);
        doOp(3'd1, 32'd10, 32'd10, 5, 3'd4, 32'd9, 32'd3);
        doOp(3'd0, 32'd1, 32'd1, 0, 3'd0, 0, 0);
        doOp(3'd7, 32'd1, 32'd1, 0, 3'd0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            rOp = 3'($urandom_range(0, 7));
            rA  = pick();
            rB  = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
            doOp(rOp, rA, rB, $urandom_range(0, 40),
                 3'($urandom_range(0, 7)), pick(),
                 ($urandom_range(0, 1) == 0) ? 32'd0 : pick());
        end

        @(negedge clock);
        start = 1'b1; operacao = 3'd4; opA = 32'd100; opB = 32'd7;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (15) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async reset ocupado", 32'(ocupado), 0);
        chk("async reset pronto", 32'(pronto), 0);
        chk("async reset erroDiv", 32'(erroDiv), 0);
        chk("async reset HiLoData", HiLoData, 0);
        mHi = '0; mLo = '0; mErr = 1'b0;
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        doOp(3'd3, 32'd5, 32'd0, 0, 3'd0, 0, 0);
        doOp(3'd2, 32'd4, 32'd5, 0, 3'd0, 0, 0);

        repeat (5) @(posedge clock);
        chk("scoreboard drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Multi-cycle multiply/divide unit owning the HI and LO registers.
- Sits directly upstream of the write-back data selector: its HiLoData output drives selector input code 000 for MFHI/MFLO.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and handles single-cycle MTHI/MTLO writes.
- Exports busy and done status so the control unit can stall on MFHI/MFLO.

Parameters:
- LARGURA, 32, operand and HI/LO width; all behaviour below is stated for the default.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request; sampled on a rising edge only while ocupado=0.
- operacao  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (ignored).
- opA  input  32  multiplicand, dividend, or MTHI/MTLO source (rs value).
- opB  input  32  multiplier or divisor.
- selHiLo  input  1  read select: 0 = LO, 1 = HI.
- HiLoData  output  32  combinational: HI when selHiLo=1, else LO.
- ocupado  output  1  busy; high while an operation is in flight.
- pronto  output  1  one-cycle done pulse for MULT/MULTU/DIV/DIVU.
- erroDiv  output  1  sticky divide-by-zero flag.

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, state=IDLE, iteration count=0, ocupado=0, pronto=0, erroDiv=0. Any in-flight operation is abandoned; HI/LO do not receive partial results.
- FSM states: IDLE, CALC, FIM.
- IDLE, start=1, operacao 001..100, no divide-by-zero (call this edge E0):
  - Latch operand magnitudes; for signed ops also latch result signs.
  - count=0; go to CALC; ocupado=1 after E0.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge; count increments. The edge completing the 32nd step (E32) moves to FIM.
- FIM, edge E33:
  - Apply sign correction and write HI/LO; go to IDLE.
  - pronto=1 and ocupado=0 for the cycle after E33.
  - The new HI/LO value is visible on HiLoData after E33.
  - Total latency is 33 edges.
- ocupado is 1 exactly in CALC and FIM.
- Multiply results: 64-bit product, HI = bits 63:32, LO = bits 31:0.
  - MULT: two's-complement signed. MULTU: unsigned.
- Divide results: LO = quotient, HI = remainder.
  - DIV: signed; quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (no trap).
- Divide by zero (DIV/DIVU with opB=0) at E0:
  - Go IDLE->FIM directly; HI/LO unchanged.
  - At E1, erroDiv=1 and pronto pulses for the cycle after E1.
- erroDiv clears on the next accepted MULT/MULTU/DIV/DIVU whose divisor is nonzero or which is a multiply.
- MTHI/MTLO in IDLE with start=1: HI (or LO) = opA at E0. No ocupado, no pronto; erroDiv unchanged.
- start while ocupado=1 is ignored; operands are not re-sampled.
- start with operacao 000 or 111 is ignored.
- HiLoData is purely combinational and shows the old HI/LO throughout CALC/FIM. Stalling MFHI/MFLO until ocupado=0 is the control unit's responsibility.
- Operand inputs may change after E0 without affecting the result.

Test Plan:
- MULT opA=0xFFFFFFFD (-3), opB=7 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB; pronto high exactly one cycle; ocupado high 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; selHiLo toggling shows each value.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- MTHI 0x1234 then DIV 5/0 -> HI stays 0x1234, LO unchanged, erroDiv=1, pronto after 1 edge. Following MULT 2x3 -> erroDiv=0, LO=6, HI=0.
- Start MULT 10x10, then pulse start with DIVU 9/3 at cycle 5 -> second request ignored; result LO=100, HI=0 at edge 33.
- Start DIVU 100/7; assert reset asynchronously mid-cycle at iteration 15 -> all outputs 0 immediately. A new MULTU 4x5 after reset release gives LO=20 at edge 33.
